// File: rtl/fsm2.sv
// Serial zero-run detector: flags MIN_ZEROS or more zeros followed by a one.
// Define FSM2_MEALY_EN for the combinational (one cycle earlier) output.
module fsm2 #(
    parameter int MIN_ZEROS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic outp
);

    localparam int CW = $clog2(MIN_ZEROS + 1);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ZERO = 2'b01;
    localparam logic [1:0] HIT  = 2'b10;

    localparam logic [CW-1:0] CMAX = CW'(MIN_ZEROS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          full;

    assign full = (cnt == CMAX);

    always_comb begin
        state_nx = IDLE;
        cnt_nx   = '0;
        unique case (1'b1)
            (state == 2'b11): begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            (!x): begin
                state_nx = ZERO;
                // The count saturates so arbitrarily long runs still match.
                if (state == ZERO)
                    cnt_nx = full ? cnt : cnt + ONE;
                else
                    cnt_nx = ONE;
            end
            default: begin
                state_nx = (state == ZERO && full) ? HIT : IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

`ifdef FSM2_MEALY_EN
    assign outp = (state == ZERO) && full && x;
`else
    assign outp = (state == HIT);
`endif

endmodule

// File: tb/tb_fsm2.sv
// Randomized and directed bench for fsm2 against a zero-run-length model.
// Mealy checks apply when FSM2_MEALY_EN is defined.
module tb_fsm2;

    localparam int MZ = 2;

    logic clk;
    logic reset;
    logic x;
    logic outp;

    int n_cmp;
    int n_err;

    // Model: length of the zero run immediately before the current bit,
    // and whether the last sampled bit completed a match.
    int zrun;
    bit hit;

    fsm2 #(.MIN_ZEROS(MZ)) dut (
        .clk  (clk),
        .reset(reset),
        .x    (x),
        .outp (outp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic b, input string tag);
        @(negedge clk);
        x = b;
        #1;
`ifdef FSM2_MEALY_EN
        chk({tag, "_mealy"}, outp, logic'(b && zrun >= MZ));
`endif
        @(posedge clk);
        if (b) begin
            hit  = (zrun >= MZ);
            zrun = 0;
        end else begin
            hit  = 1'b0;
            zrun = zrun + 1;
        end
        #1;
`ifdef FSM2_MEALY_EN
        chk({tag, "_post"}, outp, 1'b0 || (x && 1'b0));
`else
        chk(tag, outp, hit);
`endif
    endtask

    task automatic model_reset();
        zrun = 0;
        hit  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        reset = 1'b0;
        x     = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = logic'($urandom_range(0, 1));
            #1;
            chk("rst_hold", outp, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_release", outp, 1'b0);

        step(1'b0, "basic");
        step(1'b0, "basic");
        step(1'b1, "basic");
        step(1'b1, "basic_after");

        step(1'b0, "short");
        step(1'b1, "short");
        step(1'b1, "short");
        step(1'b1, "short");

        for (int i = 0; i < 4; i++) step(1'b0, "long");
        step(1'b1, "long");
        step(1'b1, "long_after");

        for (int r = 0; r < 2; r++) begin
            step(1'b0, "b2b");
            step(1'b0, "b2b");
            step(1'b1, "b2b");
        end
        step(1'b1, "b2b_after");

        step(1'b0, "midrst");
        step(1'b0, "midrst");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_low", outp, 1'b0);
        #1;
        reset = 1'b1;
        step(1'b1, "midrst_nohit");

        step(1'b0, "droprst");
        step(1'b0, "droprst");
        step(1'b1, "droprst");
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        chk("droprst_low", outp, 1'b0);
        #1;
        reset = 1'b1;
        step(1'b1, "droprst_after");

        for (int i = 0; i < 400; i++)
            step(logic'($urandom_range(0, 9) >= 6), "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
